upgrade_spawner: RTL and testbench
==================================

Name: upgrade_spawner

Overview:
- Produces the position, size and visibility of the armor pickup that the armor pickup/attach block consumes; that block returns `was_collected`.
- Waits a configurable number of frames, then draws a pseudo-random on-field location clear of both players and exposes it until collected.
- Parks the pickup off-screen whenever it is not live, so the consumer's collision check can never fire spuriously.
- Sits beside the armor block in the game top level, clocked once per frame.

Parameters:
- SPAWN_DELAY, 120, frames spent in WAIT before the first pick (and before each re-pick).
- X_MIN, 40, smallest legal UpgradeX.
- X_MAX, 600, largest legal UpgradeX.
- Y_MIN, 40, smallest legal UpgradeY.
- Y_MAX, 440, largest legal UpgradeY.
- UPGRADE_SIZE, 4, half-size driven on Upgrade_Size.
- MIN_DIST, 48, required per-axis clearance from each player centre.
- MAX_TRIES, 8, rejected candidates allowed before the fallback position is used.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero.
- RESPAWN_DELAY, 300, frames in COLLECTED before re-arming; used only with the macro.

Ports:
- frame_clk  in  1  frame clock.
- Reset  in  1  asynchronous, active-high reset.
- BallX, BallY  in  10  player 1 centre.
- Ball2X, Ball2Y  in  10  player 2 centre.
- was_collected  in  1  collected flag from the armor block.
- UpgradeX, UpgradeY  out  10  pickup centre.
- Upgrade_Size  out  10  pickup half-size.
- upgrade_visible  out  1  pickup is live and is drawn.
- armor_clear  out  1  one-frame pulse, ORed into the armor block's reset.
- spawn_count  out  4  number of spawns, saturating at 15.

Behaviour:
- Reset is asynchronous and active-high; the clock is frame_clk.
- Reset values:
  - state = WAIT, delay counter = 0, tries = 0.
  - lfsr = LFSR_SEED.
  - UpgradeX = UpgradeY = PARK (10'd1000).
  - Upgrade_Size = UPGRADE_SIZE.
  - upgrade_visible = 0, armor_clear = 0, spawn_count = 0.
- LFSR:
  - 16-bit Galois, taps 16'hB400.
  - Advances on every frame_clk in every state, so timing feeds randomness.
- Candidate derivation:
  - cx = lfsr[9:0].
  - cy = {1'b0, lfsr[15:7]}.
- Candidate acceptance requires all of:
  - X_MIN <= cx <= X_MAX and Y_MIN <= cy <= Y_MAX.
  - For each player, NOT(|cx-BallX| < MIN_DIST AND |cy-BallY| < MIN_DIST).
  - Absolute differences are computed unsigned, as the larger minus the smaller.
- States:
  - WAIT:
    - Counter increments each frame.
    - When counter == SPAWN_DELAY-1: go to PICK, clear the counter and tries.
  - PICK: one candidate is evaluated per frame.
    - Accepted: latch cx/cy into UpgradeX/UpgradeY, go to ACTIVE, spawn_count++ (saturating).
    - Rejected with tries == MAX_TRIES-1: latch fallback ((X_MIN+X_MAX)/2, (Y_MIN+Y_MAX)/2), go to ACTIVE, spawn_count++.
    - Otherwise: tries++.
  - ACTIVE:
    - upgrade_visible = 1 and the position is held.
    - was_collected sampled high goes to COLLECTED; the same edge parks the coordinates and drops upgrade_visible.
    - If was_collected is already high on entry, exit after exactly one ACTIVE frame.
  - COLLECTED:
    - Parked, invisible.
    - Terminal unless the macro is defined.
- upgrade_visible is registered and is high exactly in ACTIVE.
- Upgrade_Size is constant.
- Reset asserted in any state returns to the reset values immediately.
- Player inputs are only used in PICK; they are ignored in all other states.

Optional Feature:
UPGRADE_RESPAWN_EN
- Defined:
  - COLLECTED counts frames.
  - On counter == RESPAWN_DELAY-1: armor_clear = 1 for exactly one frame, counter cleared, state goes to WAIT.
  - A new pick follows after SPAWN_DELAY frames.
- Undefined:
  - COLLECTED holds until Reset.
  - armor_clear is tied to 0.
  - No respawn counter logic is present.

Decomposition:
- Package upgrade_pkg holds:
  - spawn_state_t enum {WAIT, PICK, ACTIVE, COLLECTED}.
  - PARK_X and PARK_Y (10'd1000).
  - LFSR_TAPS (16'hB400).
- Sub-module upgrade_lfsr16:
  - Inputs: frame_clk, Reset, seed.
  - Output: 16-bit state.
  - Reused later for other pickup types.

Test Plan:
- Reset, no further stimulus:
  - UpgradeX/Y = 1000, visible = 0 for 119 frames.
  - PICK is entered on frame 120.
  - spawn_count = 0 until the first accept.
- Players at (320,240) and (100,100), seed ACE1:
  - Every accepted UpgradeX/Y is within [40,600]×[40,440].
  - No accepted position is within 48 on both axes of either player.
  - visible rises on the frame after the accept decision.
- Players placed so every candidate is rejected (force the LFSR to out-of-range values):
  - After 8 PICK frames, position = (320,240) and visible = 1.
- ACTIVE, then was_collected = 1:
  - On the next edge, visible = 0 and UpgradeX/Y = 1000.
  - State remains COLLECTED for 1000 frames with the macro undefined.
  - armor_clear never asserts.
- Macro defined, collection at frame N:
  - armor_clear high exactly at frame N+300, for one frame.
  - Next visible after SPAWN_DELAY plus the pick latency.
  - spawn_count = 2.
- Reset asserted mid-ACTIVE, between clock edges:
  - Outputs return to reset values immediately.
  - The LFSR reloads ACE1, so the first candidate after release repeats the post-reset sequence.

Source files
------------

// File: rtl/upgrade_pkg.sv
// rtl/upgrade_pkg.sv - shared types and constants for the armor pickup spawner
package upgrade_pkg;

    typedef enum logic [1:0] {
        WAIT      = 2'd0,
        PICK      = 2'd1,
        ACTIVE    = 2'd2,
        COLLECTED = 2'd3
    } spawn_state_t;

    // Off-screen coordinate: keeps the consumer's collision test from ever matching.
    localparam logic [9:0]  PARK_X    = 10'd1000;
    localparam logic [9:0]  PARK_Y    = 10'd1000;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Unsigned distance, larger minus smaller, so no sign bit is needed.
    function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/upgrade_lfsr16.sv
// rtl/upgrade_lfsr16.sv - free-running 16-bit Galois LFSR for pickup placement
//
// Ports:
//   frame_clk  in   frame clock, advances the register every edge
//   Reset      in   asynchronous active-high reset, loads seed
//   seed       in   16-bit reload value (must be non-zero)
//   state      out  current LFSR contents
module upgrade_lfsr16
    import upgrade_pkg::*;
(
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic [15:0] seed,
    output logic [15:0] state
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    // Right-shifting Galois form: the bit shifted out folds back through the taps.
    always_comb begin
        state_d = state_q >> 1;
        if (state_q[0]) begin
            state_d = state_d ^ LFSR_TAPS;
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q <= seed;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/upgrade_spawner.sv
// rtl/upgrade_spawner.sv - timed, player-avoiding spawner for the armor pickup
//
// Optional feature macro: UPGRADE_RESPAWN_EN (re-arm after RESPAWN_DELAY frames).
//
// Ports:
//   frame_clk        in   frame clock
//   Reset            in   asynchronous active-high reset
//   BallX, BallY     in   player 1 centre (read only while picking)
//   Ball2X, Ball2Y   in   player 2 centre (read only while picking)
//   was_collected    in   pickup collected, from the armor block
//   UpgradeX/Y       out  pickup centre, parked at 1000 when not live
//   Upgrade_Size     out  constant pickup half-size
//   upgrade_visible  out  high exactly while the pickup is live
//   armor_clear      out  one-frame pulse when the pickup re-arms
//   spawn_count      out  spawns so far, saturating at 15
module upgrade_spawner
    import upgrade_pkg::*;
#(
    parameter int          SPAWN_DELAY   = 120,
    parameter int          X_MIN         = 40,
    parameter int          X_MAX         = 600,
    parameter int          Y_MIN         = 40,
    parameter int          Y_MAX         = 440,
    parameter int          UPGRADE_SIZE  = 4,
    parameter int          MIN_DIST      = 48,
    parameter int          MAX_TRIES     = 8,
`ifdef UPGRADE_RESPAWN_EN
    parameter int          RESPAWN_DELAY = 300,
`endif
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic [9:0]  BallX,
    input  logic [9:0]  BallY,
    input  logic [9:0]  Ball2X,
    input  logic [9:0]  Ball2Y,
    input  logic        was_collected,
    output logic [9:0]  UpgradeX,
    output logic [9:0]  UpgradeY,
    output logic [9:0]  Upgrade_Size,
    output logic        upgrade_visible,
    output logic        armor_clear,
    output logic [3:0]  spawn_count
);

    localparam logic [9:0]  XMIN_V     = 10'(X_MIN);
    localparam logic [9:0]  XMAX_V     = 10'(X_MAX);
    localparam logic [9:0]  YMIN_V     = 10'(Y_MIN);
    localparam logic [9:0]  YMAX_V     = 10'(Y_MAX);
    localparam logic [9:0]  DIST_V     = 10'(MIN_DIST);
    localparam logic [9:0]  FALLBACK_X = 10'((X_MIN + X_MAX) / 2);
    localparam logic [9:0]  FALLBACK_Y = 10'((Y_MIN + Y_MAX) / 2);
    localparam logic [15:0] SPAWN_LAST = 16'(SPAWN_DELAY - 1);
    localparam logic [7:0]  TRIES_LAST = 8'(MAX_TRIES - 1);
`ifdef UPGRADE_RESPAWN_EN
    localparam logic [15:0] RESP_LAST  = 16'(RESPAWN_DELAY - 1);
`endif

    spawn_state_t state_q, state_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [7:0]   tries_q, tries_d;
    logic [9:0]   x_q, x_d;
    logic [9:0]   y_q, y_d;
    logic         vis_q, vis_d;
    logic [3:0]   spawn_q, spawn_d;
    logic         clr_d;

    logic [15:0]  lfsr_state;
    logic [9:0]   cx, cy;
    logic         in_range, near_p1, near_p2, accept;

    upgrade_lfsr16 u_lfsr (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .seed      (LFSR_SEED),
        .state     (lfsr_state)
    );

    assign cx = lfsr_state[9:0];
    assign cy = {1'b0, lfsr_state[15:7]};

    always_comb begin
        in_range = (cx >= XMIN_V) && (cx <= XMAX_V) && (cy >= YMIN_V) && (cy <= YMAX_V);
        // A player blocks the candidate only when it is close on both axes.
        near_p1  = (abs_diff(cx, BallX)  < DIST_V) && (abs_diff(cy, BallY)  < DIST_V);
        near_p2  = (abs_diff(cx, Ball2X) < DIST_V) && (abs_diff(cy, Ball2Y) < DIST_V);
        accept   = in_range && !near_p1 && !near_p2;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tries_d = tries_q;
        x_d     = x_q;
        y_d     = y_q;
        spawn_d = spawn_q;
        clr_d   = 1'b0;
        unique case (state_q)
            WAIT: begin
                if (cnt_q == SPAWN_LAST) begin
                    state_d = PICK;
                    cnt_d   = '0;
                    tries_d = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            PICK: begin
                if (accept || (tries_q == TRIES_LAST)) begin
                    x_d     = accept ? cx : FALLBACK_X;
                    y_d     = accept ? cy : FALLBACK_Y;
                    state_d = ACTIVE;
                    if (spawn_q != 4'hF) begin
                        spawn_d = spawn_q + 4'd1;
                    end
                end else begin
                    tries_d = tries_q + 8'd1;
                end
            end
            ACTIVE: begin
                if (was_collected) begin
                    state_d = COLLECTED;
                    x_d     = PARK_X;
                    y_d     = PARK_Y;
                end
            end
            COLLECTED: begin
`ifdef UPGRADE_RESPAWN_EN
                if (cnt_q == RESP_LAST) begin
                    clr_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = WAIT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
        endcase
        vis_d = (state_d == ACTIVE);
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q <= WAIT;
            cnt_q   <= '0;
            tries_q <= '0;
            x_q     <= PARK_X;
            y_q     <= PARK_Y;
            vis_q   <= 1'b0;
            spawn_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tries_q <= tries_d;
            x_q     <= x_d;
            y_q     <= y_d;
            vis_q   <= vis_d;
            spawn_q <= spawn_d;
        end
    end

`ifdef UPGRADE_RESPAWN_EN
    logic clr_q;
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            clr_q <= 1'b0;
        end else begin
            clr_q <= clr_d;
        end
    end
    assign armor_clear = clr_q;
`else
    logic unused_clr;
    assign unused_clr  = clr_d;
    assign armor_clear = 1'b0;
`endif

    assign UpgradeX        = x_q;
    assign UpgradeY        = y_q;
    assign Upgrade_Size    = 10'(UPGRADE_SIZE);
    assign upgrade_visible = vis_q;
    assign spawn_count     = spawn_q;

endmodule

// File: tb/tb_upgrade_spawner.sv
// tb/tb_upgrade_spawner.sv - randomized self-checking bench for upgrade_spawner
module tb_upgrade_spawner;

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic [9:0] BallX, BallY, Ball2X, Ball2Y;
    logic       was_collected;
    logic [9:0] UpgradeX, UpgradeY, Upgrade_Size;
    logic       upgrade_visible, armor_clear;
    logic [3:0] spawn_count;

    upgrade_spawner dut (
        .frame_clk       (frame_clk),
        .Reset           (Reset),
        .BallX           (BallX),
        .BallY           (BallY),
        .Ball2X          (Ball2X),
        .Ball2Y          (Ball2Y),
        .was_collected   (was_collected),
        .UpgradeX        (UpgradeX),
        .UpgradeY        (UpgradeY),
        .Upgrade_Size    (Upgrade_Size),
        .upgrade_visible (upgrade_visible),
        .armor_clear     (armor_clear),
        .spawn_count     (spawn_count)
    );

    always #5 frame_clk = ~frame_clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          edges    = 0;
    logic [15:0] seq [0:4095];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge frame_clk);
        edges++;
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        was_collected = 1'b0;
        @(posedge frame_clk);
        #1;
        Reset = 1'b0;
        edges = 0;
    endtask

    task automatic scramble_players();
        BallX  = 10'($urandom_range(0, 1023));
        BallY  = 10'($urandom_range(0, 1023));
        Ball2X = 10'($urandom_range(0, 1023));
        Ball2Y = 10'($urandom_range(0, 1023));
    endtask

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    function automatic bit legal(input int cx, input int cy, input int px, input int py,
                                 input int qx, input int qy);
        if (cx < 40 || cx > 600 || cy < 40 || cy > 440) return 1'b0;
        if (absd(cx, px) < 48 && absd(cy, py) < 48) return 1'b0;
        if (absd(cx, qx) < 48 && absd(cy, qy) < 48) return 1'b0;
        return 1'b1;
    endfunction

    // Called at the start of a WAIT period (edges = frames already elapsed).
    // Drives 120 WAIT frames with noisy player inputs, then picks with the
    // given players and checks the outcome the reference model predicts.
    task automatic run_pick(input int px, input int py, input int qx, input int qy,
                            input bit pre_high, input int exp_count,
                            output int ox, output int oy);
        int e0 = edges;
        int k  = 7;
        int mx = 320;
        int my = 240;
        for (int f = 0; f < 120; f++) begin
            scramble_players();
            tick();
            if (f == 0) check("clear_drop", armor_clear, 0);
            if (f == 0 || f == 118) begin
                check("wait_vis", upgrade_visible, 0);
                check("wait_park", UpgradeX, 1000);
            end
        end
        BallX = 10'(px); BallY = 10'(py); Ball2X = 10'(qx); Ball2Y = 10'(qy);
        was_collected = pre_high;
        // Pick frame t sees the LFSR after e0+120+t advances.
        for (int t = 0; t < 8; t++) begin
            int cx = int'(seq[e0 + 120 + t][9:0]);
            int cy = int'(seq[e0 + 120 + t][15:7]);
            if (legal(cx, cy, px, py, qx, qy)) begin
                k = t; mx = cx; my = cy;
                break;
            end
        end
        for (int t = 0; t < k; t++) begin
            tick();
            check("pick_vis", upgrade_visible, 0);
        end
        tick();
        check("spawn_vis", upgrade_visible, 1);
        check("spawn_x", UpgradeX, mx);
        check("spawn_y", UpgradeY, my);
        check("spawn_cnt", spawn_count, exp_count);
        check("spawn_legal", (k == 7 && mx == 320 && my == 240) ||
              legal(int'(UpgradeX), int'(UpgradeY), px, py, qx, qy), 1);
        ox = mx; oy = my;
    endtask

    initial begin
        int px, py, qx, qy, ox, oy, hold;
        bit pre;
        seq[0] = 16'hACE1;
        for (int i = 1; i < 4096; i++) begin
            seq[i] = (seq[i-1] >> 1) ^ (seq[i-1][0] ? 16'hB400 : 16'h0000);
        end

        scramble_players();
        was_collected = 1'b0;
        Reset = 1'b1;
        #2;
        check("rst_x", UpgradeX, 1000);
        check("rst_y", UpgradeY, 1000);
        check("rst_size", Upgrade_Size, 4);
        check("rst_vis", upgrade_visible, 0);
        check("rst_clr", armor_clear, 0);
        check("rst_cnt", spawn_count, 0);

        for (int trial = 0; trial < 6; trial++) begin
            do_reset();
            if (trial == 0) begin
                px = 320; py = 240; qx = 100; qy = 100;
            end else begin
                px = $urandom_range(0, 639); py = $urandom_range(0, 479);
                qx = $urandom_range(0, 639); qy = $urandom_range(0, 479);
            end
            pre = (trial >= 4);
            run_pick(px, py, qx, qy, pre, 1, ox, oy);
            if (!pre) begin
                hold = $urandom_range(0, 5);
                for (int h = 0; h < hold; h++) begin
                    scramble_players();
                    tick();
                    check("hold_x", UpgradeX, ox);
                    check("hold_vis", upgrade_visible, 1);
                end
                was_collected = 1'b1;
            end
            tick();
            check("coll_vis", upgrade_visible, 0);
            check("coll_x", UpgradeX, 1000);
            check("coll_y", UpgradeY, 1000);
            was_collected = 1'b0;
`ifdef UPGRADE_RESPAWN_EN
            if (trial == 0) begin
                for (int f = 0; f < 299; f++) begin
                    tick();
                    if (armor_clear !== 1'b0) check("clr_early", armor_clear, 0);
                end
                tick();
                check("clr_pulse", armor_clear, 1);
                run_pick(px, py, qx, qy, 1'b0, 2, ox, oy);
                continue;
            end
`endif
            for (int f = 0; f < ((trial == 0) ? 1000 : 10); f++) begin
                scramble_players();
                was_collected = 1'($urandom_range(0, 1));
                tick();
                if (f % 100 == 0 || upgrade_visible !== 1'b0 || armor_clear !== 1'b0) begin
                    check("term_vis", upgrade_visible, 0);
                    check("term_clr", armor_clear, 0);
                    check("term_x", UpgradeX, 1000);
                end
            end
            check("term_cnt", spawn_count, 1);
        end

        // Every candidate rejected: fallback to the field centre after 8 tries.
        do_reset();
        force dut.lfsr_state = 16'hFFFF;
        for (int f = 0; f < 127; f++) tick();
        check("fb_pre_vis", upgrade_visible, 0);
        tick();
        check("fb_vis", upgrade_visible, 1);
        check("fb_x", UpgradeX, 320);
        check("fb_y", UpgradeY, 240);
        release dut.lfsr_state;

        // Reset between edges while ACTIVE; the sequence must replay identically.
        do_reset();
        px = $urandom_range(0, 639); py = $urandom_range(0, 479);
        qx = $urandom_range(0, 639); qy = $urandom_range(0, 479);
        run_pick(px, py, qx, qy, 1'b0, 1, ox, oy);
        tick();
        tick();
        #2 Reset = 1'b1;
        #1;
        check("mid_rst_vis", upgrade_visible, 0);
        check("mid_rst_x", UpgradeX, 1000);
        check("mid_rst_cnt", spawn_count, 0);
        #1 Reset = 1'b0;
        edges = 0;
        run_pick(px, py, qx, qy, 1'b0, 1, px, py);
        check("replay_x", UpgradeX, ox);
        check("replay_y", UpgradeY, oy);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
